// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-requester round-robin arbiter with lockable grants
// in front of a single-port data memory with combinational read data.
module data_memory_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_WE,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    input  logic [DW-1:0] mem_RD
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          win0, win1;
    logic          lock_gnt;
    logic          same_own;
    logic [CW-1:0] cnt_inc;

    // Arbitration: the lock owner wins while it requests, otherwise round-robin on ties.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (state_q == OWN0 && m0_req) begin
            win0 = 1'b1;
        end else if (state_q == OWN1 && m1_req) begin
            win1 = 1'b1;
        end else if (m0_req && m1_req) begin
            win0 = last_q;
            win1 = ~last_q;
        end else begin
            win0 = m0_req;
            win1 = m1_req;
        end
    end

    // Grants and memory port; reset kills them immediately, without waiting for an edge.
    always_comb begin
        m0_gnt = win0 & rst;
        m1_gnt = win1 & rst;
        mem_WE = 1'b0;
        mem_A  = '0;
        mem_WD = '0;
        if (m0_gnt) begin
            mem_WE = m0_we;
            mem_A  = m0_addr;
            mem_WD = m0_wdata;
        end else if (m1_gnt) begin
            mem_WE = m1_we;
            mem_A  = m1_addr;
            mem_WD = m1_wdata;
        end
    end

    // Lock FSM next state: count consecutive locked grants, release at LOCK_MAX.
    always_comb begin
        state_d  = IDLE;
        cnt_d    = '0;
        last_d   = last_q;
        lock_gnt = (win0 & m0_lock) | (win1 & m1_lock);
        same_own = (win0 && state_q == OWN0) || (win1 && state_q == OWN1);
        cnt_inc  = (same_own ? cnt_q : CW'(0)) + CW'(1);
        if (win0) begin
            last_d = 1'b0;
        end
        if (win1) begin
            last_d = 1'b1;
        end
        if (lock_gnt && (cnt_inc < CW'(LOCK_MAX))) begin
            state_d = win0 ? OWN0 : OWN1;
            cnt_d   = cnt_inc;
        end
    end

    // Read capture: latch memory data for the granted reader and flag it for one cycle.
    always_comb begin
        rvalid_d = {win1 & ~m1_we, win0 & ~m0_we};
        rdata0_d = rvalid_d[0] ? mem_RD : rdata0_q;
        rdata1_d = rvalid_d[1] ? mem_RD : rdata1_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios, a rule-level reference
// model checked every falling edge, and hand-computed literal expectations.
module tb_data_memory_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int LOCK_MAX = 4;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: last winner, lock owner (-1 none), locked run length.
    int            m_last = 1;
    int            m_owner = -1;
    int            m_run = 0;
    logic          m_rv0 = 1'b0;
    logic          m_rv1 = 1'b0;
    logic [DW-1:0] m_rd0 = '0;
    logic [DW-1:0] m_rd1 = '0;
    logic [DW-1:0] m_mem [logic [AW-1:0]];

    logic [DW-1:0] env_mem [64];

    data_memory_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_lock  (m0_lock),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_lock  (m1_lock),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata (m1_rdata),
        .mem_WE   (mem_we),
        .mem_A    (mem_a),
        .mem_WD   (mem_wd),
        .mem_RD   (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
        return DW'(32'hA000_0000 ^ a);
    endfunction

    // Winner by the arbitration rules: owner keeps it, ties alternate, single requester wins.
    function automatic int winner(input logic rs, input logic r0, input logic r1);
        if (!rs) return -1;
        if (m_owner == 0 && r0) return 0;
        if (m_owner == 1 && r1) return 1;
        if (r0 && r1) return (m_last == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Data memory: write request seen mid-cycle is committed on the closing edge.
    assign mem_rd = env_mem[mem_a[5:0]];
    initial begin
        logic          pend;
        logic [5:0]    pa;
        logic [DW-1:0] pd;
        for (int i = 0; i < 64; i++) env_mem[i] = preload(AW'(i));
        forever begin
            @(negedge clk);
            pend = mem_we;
            pa   = mem_a[5:0];
            pd   = mem_wd;
            @(posedge clk);
            if (pend && rst) env_mem[pa] = pd;
        end
    end

    // Reference model update on each edge or on async reset.
    initial begin
        int            w;
        logic          wr, lk;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_last  = 1;
                m_owner = -1;
                m_run   = 0;
                m_rv0   = 1'b0;
                m_rv1   = 1'b0;
                m_rd0   = '0;
                m_rd1   = '0;
            end else begin
                w     = winner(1'b1, m0_req, m1_req);
                m_rv0 = 1'b0;
                m_rv1 = 1'b0;
                if (w < 0) begin
                    m_owner = -1;
                    m_run   = 0;
                end else begin
                    wr = (w == 0) ? m0_we : m1_we;
                    lk = (w == 0) ? m0_lock : m1_lock;
                    a  = (w == 0) ? m0_addr : m1_addr;
                    d  = (w == 0) ? m0_wdata : m1_wdata;
                    if (wr) begin
                        m_mem[a] = d;
                    end else begin
                        d = m_mem.exists(a) ? m_mem[a] : preload(a);
                        if (w == 0) begin m_rv0 = 1'b1; m_rd0 = d; end
                        else        begin m_rv1 = 1'b1; m_rd1 = d; end
                    end
                    if (lk) begin
                        m_run = (w == m_owner) ? m_run + 1 : 1;
                        if (m_run >= LOCK_MAX) begin
                            m_owner = -1;
                            m_run   = 0;
                        end else begin
                            m_owner = w;
                        end
                    end else begin
                        m_owner = -1;
                        m_run   = 0;
                    end
                    m_last = w;
                end
            end
        end
    end

    // Compare all DUT outputs against the model every falling edge.
    initial begin
        int            w;
        logic          e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd;
        forever begin
            @(negedge clk);
            w    = winner(rst, m0_req, m1_req);
            e_we = 1'b0;
            e_a  = '0;
            e_wd = '0;
            if (w == 0) begin e_we = m0_we; e_a = m0_addr; e_wd = m0_wdata; end
            else if (w == 1) begin e_we = m1_we; e_a = m1_addr; e_wd = m1_wdata; end
            chk("cmp_m0_gnt",    32'(m0_gnt),    32'(w == 0));
            chk("cmp_m1_gnt",    32'(m1_gnt),    32'(w == 1));
            chk("cmp_mem_we",    32'(mem_we),    32'(e_we));
            chk("cmp_mem_a",     32'(mem_a),     32'(e_a));
            chk("cmp_mem_wd",    32'(mem_wd),    32'(e_wd));
            chk("cmp_m0_rvalid", 32'(m0_rvalid), 32'(m_rv0));
            chk("cmp_m1_rvalid", 32'(m1_rvalid), 32'(m_rv1));
            chk("cmp_m0_rdata",  32'(m0_rdata),  32'(m_rd0));
            chk("cmp_m1_rdata",  32'(m1_rdata),  32'(m_rd1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic drive0(input logic rq, input logic we, input logic lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = rq; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive1(input logic rq, input logic we, input logic lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = rq; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Directed scenarios.
    initial begin
        int cexp [6];
        cexp = '{2, 2, 2, 2, 1, 2};
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;

        // Requests during reset are ignored; reset values.
        m0_req = 1'b1;
        m1_req = 1'b1;
        tick();
        tick();
        #2;
        chk("rst_gnt",    32'({m1_gnt, m0_gnt}),       32'd0);
        chk("rst_mem_we", 32'(mem_we),                 32'd0);
        chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        idle_inputs();
        tick();
        rst = 1'b1;

        // m0 writes addr 10, then reads it back.
        drive0(1'b1, 1'b1, 1'b0, 32'd10, 32'h00BC614E);
        #2;
        chk("a_c1_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("a_c1_mem_we", 32'(mem_we), 32'd1);
        tick();
        drive0(1'b1, 1'b0, 1'b0, 32'd10, 32'd0);
        #2;
        chk("a_c2_mem_we", 32'(mem_we), 32'd0);
        tick();
        idle_inputs();
        chk("a_c3_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("a_c3_m0_rdata",  m0_rdata,       32'h00BC614E);
        tick();
        chk("a_c4_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("a_c4_m0_rdata",  m0_rdata,       32'h00BC614E);

        // Both read continuously after reset: m0, m1, m0, m1.
        do_reset();
        drive0(1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
        drive1(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("b_gnt", 32'({m1_gnt, m0_gnt}), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("b_rvalid", 32'({m1_rvalid, m0_rvalid}),
                (k == 0) ? 32'd0 : ((k % 2 == 1) ? 32'd1 : 32'd2));
            tick();
        end
        idle_inputs();
        chk("b_last_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd2);
        chk("b_m0_rdata", m0_rdata, 32'hA000_0003);
        chk("b_m1_rdata", m1_rdata, 32'hA000_0005);
        tick();

        // Locked m1 against a requesting m0: 4 x m1, 1 x m0, then m1 again.
        drive0(1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
        tick();
        drive0(1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
        drive1(1'b1, 1'b0, 1'b1, 32'd4, 32'd0);
        for (int k = 0; k < 6; k++) begin
            #2;
            chk("c_lock_gnt", 32'({m1_gnt, m0_gnt}), 32'(cexp[k]));
            tick();
        end
        idle_inputs();
        tick();

        // Lock dropped: owner keeps this cycle, then round-robin resumes.
        drive0(1'b1, 1'b0, 1'b1, 32'd6, 32'd0);
        #2 chk("c2_own_gnt", 32'({m1_gnt, m0_gnt}), 32'd1);
        tick();
        drive0(1'b1, 1'b0, 1'b0, 32'd6, 32'd0);
        drive1(1'b1, 1'b0, 1'b0, 32'd8, 32'd0);
        #2 chk("c2_held_gnt", 32'({m1_gnt, m0_gnt}), 32'd1);
        tick();
        #2 chk("c2_rr_gnt", 32'({m1_gnt, m0_gnt}), 32'd2);
        tick();
        idle_inputs();

        // Owner drops req: the other requester is served at once.
        drive1(1'b1, 1'b0, 1'b1, 32'd9, 32'd0);
        #2 chk("c3_own_gnt", 32'({m1_gnt, m0_gnt}), 32'd2);
        tick();
        drive1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive0(1'b1, 1'b0, 1'b0, 32'd9, 32'd0);
        #2 chk("c3_drop_gnt", 32'({m1_gnt, m0_gnt}), 32'd1);
        tick();
        idle_inputs();
        tick();

        // m0 writes addr 20 while m1 reads addr 20.
        do_reset();
        drive0(1'b1, 1'b1, 1'b0, 32'd20, 32'h05397FB1);
        drive1(1'b1, 1'b0, 1'b0, 32'd20, 32'd0);
        #2 chk("d_first_gnt", 32'({m1_gnt, m0_gnt}), 32'd1);
        tick();
        drive0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2 chk("d_second_gnt", 32'({m1_gnt, m0_gnt}), 32'd2);
        tick();
        idle_inputs();
        chk("d_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("d_m1_rdata",  m1_rdata,       32'h05397FB1);
        tick();

        // Reset asserted mid-cycle during an m1 write grant.
        drive1(1'b1, 1'b1, 1'b0, 32'd7, 32'hDEADBEEF);
        #1;
        chk("e_pre_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("e_pre_mem_we", 32'(mem_we), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("e_rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("e_rst_mem_we", 32'(mem_we), 32'd0);
        chk("e_rst_m1_rdata", m1_rdata, 32'd0);
        idle_inputs();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2 chk("e_post_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
            tick();
        end

        // Reset cutting an m0 read produces no rvalid after release.
        drive0(1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
        #2 chk("e2_pre_m0_gnt", 32'(m0_gnt), 32'd1);
        #1 rst = 1'b0;
        #1 chk("e2_rst_m0_gnt", 32'(m0_gnt), 32'd0);
        idle_inputs();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2 chk("e2_post_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
            tick();
        end

        // Three idle cycles.
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("f_gnt",    32'({m1_gnt, m0_gnt}),       32'd0);
            chk("f_mem_we", 32'(mem_we),                 32'd0);
            chk("f_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
            tick();
        end

        // The write cut by reset must not have reached memory.
        drive1(1'b1, 1'b0, 1'b0, 32'd7, 32'd0);
        tick();
        idle_inputs();
        chk("g_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("g_m1_rdata",  m1_rdata,       32'hA000_0007);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the address width of the requester ports and the memory port.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width of the requester ports and the memory port.
REQ-003 The block SHALL have parameter LOCK_MAX, default 4, meaning the maximum number of consecutive locked grants to one requester.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports m0_req / m1_req, input, 1 bit each: access request.
REQ-007 The block SHALL have ports m0_we / m1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports m0_lock / m1_lock, input, 1 bit each: request to keep the grant next cycle.
REQ-009 The block SHALL have ports m0_addr / m1_addr, input, AW bits each: word address.
REQ-010 The block SHALL have ports m0_wdata / m1_wdata, input, DW bits each: write data.
REQ-011 The block SHALL have ports m0_gnt / m1_gnt, output, 1 bit each: access performed this cycle.
REQ-012 The block SHALL have ports m0_rvalid / m1_rvalid, output, 1 bit each: read data valid.
REQ-013 The block SHALL have ports m0_rdata / m1_rdata, output, DW bits each: registered read data.
REQ-014 The block SHALL have port mem_WE, output, 1 bit: data memory write enable.
REQ-015 The block SHALL have port mem_A, output, AW bits: data memory address.
REQ-016 The block SHALL have port mem_WD, output, DW bits: data memory write data.
REQ-017 The block SHALL have port mem_RD, input, DW bits: data memory combinational read data.

Function
REQ-018 The block SHALL perform at most one memory access per cycle; gnt outputs SHALL be combinational from req, lock state and priority pointer, and SHALL be one-hot or zero.
REQ-019 With a single requester active, that requester SHALL be granted in the same cycle (zero wait).
REQ-020 With both requesting and no lock in force, the requester other than the last granted one SHALL win (round-robin); the 1-bit pointer last SHALL update to the winner at the clock edge.
REQ-021 The memory port SHALL mux the winner: mem_A = addr, mem_WD = wdata, mem_WE = gnt & we; with no grant, mem_WE SHALL be 0 and mem_A/mem_WD SHALL hold 0.
REQ-022 On a granted read, the block SHALL capture mem_RD into that requester's rdata and pulse its rvalid for exactly one cycle, one cycle after the grant (latency 1).
REQ-023 rdata SHALL hold its value until the next read for that requester; a write SHALL NOT pulse rvalid.
REQ-024 The FSM SHALL have states IDLE, OWN0 and OWN1: a grant with lock=1 SHALL move to OWNx, and in OWNx requester x SHALL win even if the other requests.
REQ-025 A locked-grant counter SHALL increment per locked grant; OWNx SHALL exit to IDLE when lock drops, when req drops, or after LOCK_MAX consecutive grants.
REQ-026 When OWNx exits on the LOCK_MAX limit, the other requester, if requesting, SHALL win the next cycle; the counter SHALL clear on exit.
REQ-027 A write and a read to the same address in consecutive cycles SHALL return the newly written data (memory writes on the edge ending the grant cycle).
REQ-028 A requester dropping req SHALL be accepted at any cycle; there is no outstanding-transaction state beyond the rvalid pulse.

Reset
REQ-029 On rst=0, the block SHALL immediately force gnt=0, rvalid=0, rdata=0, mem_WE=0, FSM=IDLE, counter=0 and last=1 (so m0 wins the first tie).
REQ-030 The block SHALL ignore requests while rst=0; an access cut by reset SHALL NOT produce rvalid after release.

Verification
REQ-031 The bench SHALL cover: m0 writes addr 10, data 0x00BC614E, then reads addr 10 -> m0_gnt=1 and mem_WE=1 in cycle 1; m0_rvalid=1 with m0_rdata=0x00BC614E in cycle 3.
REQ-032 The bench SHALL cover: after reset, m0 and m1 both read continuously -> grants m0, m1, m0, m1; each rvalid one cycle after its grant.
REQ-033 The bench SHALL cover: m1 with lock=1 requesting for 6 cycles while m0 requests -> m1 granted 4 cycles, then m0 for 1, then m1 resumes.
REQ-034 The bench SHALL cover: m0 writes addr 20 with 0x05397FB1 while m1 reads addr 20 -> m0 granted first; m1 read returns 0x05397FB1.
REQ-035 The bench SHALL cover: rst=0 asserted mid-cycle during an m1 write grant -> mem_WE and m1_gnt drop without waiting for a clock edge, and no rvalid is seen after release.
REQ-036 The bench SHALL cover: no requests for 3 cycles -> mem_WE=0, all gnt=0 and all rvalid=0.
